// File: rtl/morty_pkg.sv
// Shared Wishbone widths, FSM state encoding and the address range helper
// for the morty data memory.
package morty_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Unsigned subtraction on purpose: addresses below base wrap high and fail.
    function automatic logic word_out_of_range(input logic [WB_AW-1:0] adr,
                                               input logic [WB_AW-1:0] base,
                                               input logic [WB_AW-1:0] words);
        logic [WB_AW-1:0] off;
        off = adr - base;
        return (off >> 2) >= words;
    endfunction

endpackage

// File: rtl/morty_dmem_ram.sv
// Single-port word RAM with per-byte write enables and registered read data.
// Read-first: a write and a read in the same enabled cycle return the old word.
module morty_dmem_ram
    import morty_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic             clk_i,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [WB_SW-1:0] i_be,
    input  logic [AW-1:0]    i_addr,
    input  logic [WB_DW-1:0] i_wdata,
    output logic [WB_DW-1:0] o_rdata
);

    logic [WB_DW-1:0] r_mem [MEM_WORDS];
    logic [WB_DW-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < WB_SW; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/morty_wb_dmem.sv
// Wishbone B4 classic slave data memory: byte-enabled RAM behind an
// IDLE/WAIT/RESP handshake FSM with programmable wait states and range errors.
module morty_wb_dmem
    import morty_pkg::*;
#(
    parameter int unsigned      MEM_WORDS   = 1024,
    parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned      WAIT_STATES = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WB_AW-1:0] wbs_adr_i,
    input  logic [WB_DW-1:0] wbs_dat_i,
    input  logic [WB_SW-1:0] wbs_sel_i,
    input  logic             wbs_we_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    output logic [WB_DW-1:0] wbs_dat_o,
    output logic             wbs_ack_o,
    output logic             wbs_err_o
);

    localparam int               IDX_W    = $clog2(MEM_WORDS);
    localparam logic [WB_AW-1:0] WORDS    = WB_AW'(MEM_WORDS);
    localparam logic [3:0]       LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [3:0]       r_cnt;
    logic [WB_AW-1:0] r_adr;
    logic [WB_DW-1:0] r_dat;
    logic [WB_SW-1:0] r_sel;
    logic             r_we;
    logic             r_err_flag;
    logic             r_ack;
    logic             r_err;

    logic             w_req;
    logic             w_idle;
    logic             w_accept;
    logic [WB_AW-1:0] w_adr;
    logic [WB_DW-1:0] w_dat;
    logic [WB_SW-1:0] w_sel;
    logic             w_we;
    logic             w_err_cur;
    logic [WB_AW-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_enter_resp;
    logic             w_ram_en;
    logic             w_ram_we;
    logic [WB_DW-1:0] w_rdata;

    assign w_req    = wbs_cyc_i & wbs_stb_i;
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & w_req;

    // With zero wait states the RAM is accessed on the accept edge itself,
    // so the request fields come straight from the bus while idle.
    assign w_adr     = w_idle ? wbs_adr_i : r_adr;
    assign w_dat     = w_idle ? wbs_dat_i : r_dat;
    assign w_sel     = w_idle ? wbs_sel_i : r_sel;
    assign w_we      = w_idle ? wbs_we_i  : r_we;
    assign w_err_cur = w_idle ? (word_out_of_range(wbs_adr_i, BASE_ADDR, WORDS) | (wbs_sel_i == '0))
                              : r_err_flag;

    assign w_off = w_adr - BASE_ADDR;
    assign w_idx = IDX_W'(w_off >> 2);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                if (!wbs_cyc_i)             w_next = ST_IDLE;
                else if (r_cnt == LAST_CNT) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_enter_resp = (w_next == ST_RESP);
        w_ram_en     = w_enter_resp & rst_ni;
        w_ram_we     = w_ram_en & w_we & ~w_err_cur & wbs_cyc_i & wbs_stb_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= 4'd0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_adr      <= wbs_adr_i;
            r_dat      <= wbs_dat_i;
            r_sel      <= wbs_sel_i;
            r_we       <= wbs_we_i;
            r_err_flag <= w_err_cur;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_enter_resp & ~w_err_cur;
            r_err <= w_enter_resp & w_err_cur;
        end
    end

    morty_dmem_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_be    (w_sel),
        .i_addr  (w_idx),
        .i_wdata (w_dat),
        .o_rdata (w_rdata)
    );

    assign wbs_ack_o = r_ack;
    assign wbs_err_o = r_err;
    assign wbs_dat_o = r_ack ? w_rdata : '0;

endmodule
